// File: rtl/nv_ram_rdctl_pkg.sv
// nv_ram_rdctl_pkg: shared types for the 128x512 RAM read-burst controller.
// Holds the default widths, the FSM encoding and the output-buffer entry type.
package nv_ram_rdctl_pkg;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DW_DEF-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/nv_ram_rdctl_skid2.sv
// nv_ram_rdctl_skid2: 2-entry FIFO with a registered head entry.
// Ports: clk/rst_n, push+din, pop, head (current output entry), occ (0..2).
module nv_ram_rdctl_skid2
    import nv_ram_rdctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rd_entry_t  din,
    input  logic       pop,
    output rd_entry_t  head,
    output logic [1:0] occ
);

    rd_entry_t tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind
                    // whatever remains after the pop.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && occ == 2'd2 && !pop)
    ) else $error("skid2 overflow: push into full buffer");

endmodule

// File: rtl/nv_ram_rws_128x512_rdctl.sv
// nv_ram_rws_128x512_rdctl: read-side burst controller for the 128x512 RAM.
// Ports: cmd_* burst command, ram_re/ram_ra/ram_dout RAM read port,
//        dat_* valid/ready output stream with last, busy while not IDLE.
module nv_ram_rws_128x512_rdctl
    import nv_ram_rdctl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic          dat_valid,
    input  logic          dat_ready,
    output logic [DW-1:0] dat_pd,
    output logic          dat_last,
    output logic          busy
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    rd_state_t     state, state_nxt;
    logic [AW-1:0] addr, remain;
    logic          pend, pend_last;
    logic          pop, issue, is_last;
    logic [1:0]    occ;
    logic [2:0]    level;
    rd_entry_t     din, head;

    assign pop     = dat_valid & dat_ready;
    // Entries that will be held or in flight after this cycle's pop;
    // issuing only below 2 keeps the 2-entry buffer from overflowing.
    assign level   = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    assign issue   = (state == RUN) && (level < 3'd2);
    assign is_last = (remain == '0);

    assign ram_re    = issue;
    assign ram_ra    = addr;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (cmd_valid) state_nxt = RUN;
            RUN:   if (issue && is_last) state_nxt = DRAIN;
            // Leave as soon as the buffer will be empty next cycle so
            // busy drops right after the final pop.
            DRAIN: if (!pend && (occ == 2'd0 || (occ == 2'd1 && pop)))
                       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state     <= IDLE;
            addr      <= '0;
            remain    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= issue;
            pend_last <= issue & is_last;
            if (cmd_valid && cmd_ready) begin
                addr   <= cmd_addr;
                remain <= cmd_len;
            end else if (issue) begin
                addr   <= addr + ONE;
                remain <= remain - ONE;
            end
        end
    end

    assign din.last = pend_last;
    assign din.data = ram_dout;

    nv_ram_rdctl_skid2 u_buf (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .push  (pend),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .occ   (occ)
    );

    assign dat_valid = (occ != 2'd0);
    assign dat_pd    = head.data;
    assign dat_last  = head.last;

endmodule

// File: doc/nv_ram_rws_128x512_rdctl.md
# nv_ram_rws_128x512_rdctl

Read-side burst controller for the 128x512 simple-dual-port RAM (1-cycle registered-address read, data held on `dout` until the next `re`). It accepts a burst command (start address, beat count) and drives `ram_re`/`ram_ra`. It captures each returned word into a 2-entry output buffer and presents it as a valid/ready stream with `last` marking. Full throughput is one beat per cycle. It sits between the RAM read port and any downstream consumer (e.g. CDMA/CSC data paths); the RAM write port is owned elsewhere.

## Interface
- `AW`, 7, RAM address width (depth 2^AW = 128)
- `DW`, 512, data width
- `nvdla_core_clk`  in  1  core clock, all flops rising-edge
- `nvdla_core_rstn`  in  1  reset; asynchronous assert, active-low
- `cmd_valid`  in  1  burst command valid
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_addr`  in  AW  first word address
- `cmd_len`  in  AW  beats minus one (0 → 1 beat, 127 → 128 beats)
- `ram_re`  out  1  RAM read enable
- `ram_ra`  out  AW  RAM read address
- `ram_dout`  in  DW  RAM read data, valid the cycle after `ram_re`
- `dat_valid`  out  1  output beat valid
- `dat_ready`  in  1  downstream accept
- `dat_pd`  out  DW  output beat data
- `dat_last`  out  1  final beat of burst
- `busy`  out  1  burst in progress (state ≠ IDLE)

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On handshake, latch `addr`=`cmd_addr` and `remain`=`cmd_len`, then go to RUN.
  - RUN: issue reads. After the read with `remain`==0 is issued, go to DRAIN.
  - DRAIN: wait until buffer empty and no read pending, then go to IDLE.
- Commands are accepted only in IDLE, so a new command is never taken in the same cycle as the final pop.
- Issue rule: `ram_re` = RUN & (`occ` + `pend` − `pop`) < 2.
  - `occ` = buffer entries (0..2).
  - `pend` = read issued in the previous cycle.
  - `pop` = `dat_valid & dat_ready`.
- `ram_ra` = `addr` register. On each issue: `addr` ← `addr`+1 mod 2^AW (wrap 127→0), and `remain` decrements.
- Capture: `pend` flop is set by `ram_re`. While `pend`=1, `ram_dout` is written into the buffer at the clock edge, together with a last tag (tag=1 for the read issued with `remain`==0).
- Output is driven from the buffer head: `dat_valid` = `occ`≠0; `dat_pd`, `dat_last` come from the head entry.
  - Head is stable while `dat_valid & !dat_ready`.
  - Buffer push and pop may occur in the same cycle.
- Buffer overflow is impossible by the issue rule. A verification assertion must check that a push with `occ`==2 and no pop never occurs.
- Captured data must not depend on later RAM writes.
- Reset (any cycle, including mid-burst) forces:
  - state IDLE; `occ`, `pend`, `addr`, `remain` = 0.
  - `ram_re`=0, `ram_ra`=0, `dat_valid`=0, `dat_last`=0, `dat_pd`=0, `busy`=0, `cmd_ready`=1.
  - Any in-flight RAM read is discarded; RAM contents are untouched.

## Timing
- Cycle N cmd handshake → N+1 `ram_re` with `ram_ra`=`cmd_addr` → N+2 capture edge → N+3 `dat_valid`. First-beat latency is 3 cycles.
- With `dat_ready` held at 1: one beat per cycle, so an L-beat burst finishes in L+3 cycles from the handshake.
- `dat_ready` low for k cycles stalls issue within 1 cycle. No beat is lost or duplicated.
- `busy` falls in the cycle after the last pop. `cmd_ready` rises in that same cycle.

## Structure
- Shared package `nv_ram_rdctl_pkg` holds:
  - `AW`/`DW` defaults.
  - FSM encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Buffer entry type (data + last tag).
- Sub-module `nv_ram_rdctl_skid2`: 2-entry FIFO with registered head, push/pop/`occ`, async active-low reset. The top level holds the FSM, address/length counters and issue logic.

## Test plan
- Single beat: cmd addr=5 len=0, RAM[5]=A, ready=1 → `ram_re` once at N+1 with ra=5; `dat_valid`=1, `dat_pd`=A, `dat_last`=1 at N+3; `busy` low at N+4.
- Full burst with wrap: addr=100 len=127 → ra sequence 100..127,0..99; 128 consecutive beats with no gaps; only beat 128 has `last`=1.
- Backpressure: len=15, `dat_ready` random 50% → all 16 beats in order, each `dat_pd` held stable while stalled; the occupancy assertion never fires.
- Write after capture: after beat k is captured, write a new value to address k's RAM location while stalled → `dat_pd` still shows the original value.
- Reset mid-burst: drop `nvdla_core_rstn` at beat 7 of 32 → all outputs reach reset values immediately; a new cmd addr=0 len=3 then returns exactly 4 correct beats.
- Back-to-back commands: cmd_valid held with a second cmd → second cmd accepted only in the cycle `busy`=0, and its beats follow with no leftover data from the first burst.
